fp32_add_issue: RTL

Operand issue and result-capture stage wrapped around the combinational FP32 adder datapath. It accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry FIFO. Each head entry is classified and resolved in one of two ways: IEEE special cases (NaN, Inf, zero, flushed subnormal) are computed locally; normal pairs are driven to the adder. The result is registered into a stallable output stage, giving the adder a clean registered boundary on both sides.

---
 rtl/fp32_pkg.sv | 44 ++++
 rtl/fp32_classify.sv | 20 ++
 rtl/fp32_add_issue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: rounding modes, canonical quiet NaN, operand classes,
// the FIFO entry layout and IEEE-754 field helpers.
package fp32_pkg;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  rmode;
   } issue_entry_t;

   function automatic logic fp_sign(input logic [31:0] value);
      return value[31];
   endfunction

   function automatic logic [7:0] fp_exp(input logic [31:0] value);
      return value[30:23];
   endfunction

   function automatic logic [22:0] fp_mant(input logic [31:0] value);
      return value[22:0];
   endfunction

   // Subnormals are flushed to a zero that keeps the operand's sign.
   function automatic logic [31:0] fp_ftz(input logic [31:0] value);
      if (fp_exp(value) == 8'h00 && fp_mant(value) != 23'd0)
         return {value[31], 31'd0};
      return value;
   endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier. Operands reach it already flushed,
// so any zero exponent is treated as a zero.
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] value,
   output fp_class_t   cls,
   output logic        sign
);

   always_comb begin
      cls  = NORM;
      sign = fp_sign(value);
      if (fp_exp(value) == 8'h00)
         cls = ZERO;
      else if (fp_exp(value) == 8'hFF)
         cls = (fp_mant(value) != 23'd0) ? NAN : INF;
   end

endmodule

// File: rtl/fp32_add_issue.sv
// Operand issue FIFO and stallable result register around a combinational FP32 adder.
// Defining FP32_ISSUE_STATS_EN adds the stat_total/stat_special load counters. FIFO_DEPTH must be 2 or 4.
module fp32_add_issue
   import fp32_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_sub,
   input  logic [1:0]  in_rmode,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic [1:0]  add_rmode,
   input  logic [31:0] add_y,
   input  logic        add_error,
   input  logic        add_overflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_y,
   output logic        out_error,
   output logic        out_overflow
`ifdef FP32_ISSUE_STATS_EN
   ,
   output logic [15:0] stat_total,
   output logic [15:0] stat_special
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   issue_entry_t       mem [FIFO_DEPTH];
   issue_entry_t       new_entry;
   issue_entry_t       head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               head_valid;
   logic               push;
   logic               load;

   fp_class_t          cls_a;
   fp_class_t          cls_b;
   logic               sign_a;
   logic               sign_b;
   logic [31:0]        res_y;
   logic               res_error;
   logic               res_overflow;
   logic               res_special;

   // in_ready looks only at occupancy, so a full FIFO refuses even when popping.
   assign in_ready   = (count != FULL_CNT);
   assign head_valid = (count != '0);
   assign push       = in_valid && in_ready;
   assign load       = head_valid && (!out_valid || out_ready);
   assign head       = mem[rd_ptr];

   always_comb begin
      new_entry.a     = fp_ftz(in_a);
      new_entry.b     = fp_ftz({in_b[31] ^ in_sub, in_b[30:0]});
      new_entry.rmode = in_rmode;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= new_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         if (load)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, load})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // The adder sees registered FIFO state only, zeroed while the FIFO is empty.
   always_comb begin
      add_a     = '0;
      add_b     = '0;
      add_rmode = '0;
      if (head_valid) begin
         add_a     = head.a;
         add_b     = head.b;
         add_rmode = head.rmode;
      end
   end

   fp32_classify u_classify_a (
      .value (add_a),
      .cls   (cls_a),
      .sign  (sign_a)
   );

   fp32_classify u_classify_b (
      .value (add_b),
      .cls   (cls_b),
      .sign  (sign_b)
   );

   always_comb begin
      res_y        = add_y;
      res_error    = add_error;
      res_overflow = add_overflow;
      res_special  = 1'b1;
      if (cls_a == NAN || cls_b == NAN) begin
         res_y        = QNAN;
         res_error    = 1'b1;
         res_overflow = 1'b0;
      end else if (cls_a == INF && cls_b == INF && sign_a != sign_b) begin
         res_y        = QNAN;
         res_error    = 1'b1;
         res_overflow = 1'b0;
      end else if (cls_a == INF || cls_b == INF) begin
         res_y        = (cls_a == INF) ? add_a : add_b;
         res_error    = 1'b0;
         res_overflow = 1'b0;
      end else if (cls_a == ZERO && cls_b == ZERO) begin
         if (sign_a == sign_b)
            res_y = add_a;
         else
            res_y = (add_rmode == RM_RDN) ? 32'h80000000 : 32'h00000000;
         res_error    = 1'b0;
         res_overflow = 1'b0;
      end else if (cls_a == ZERO || cls_b == ZERO) begin
         res_y        = (cls_a == ZERO) ? add_b : add_a;
         res_error    = 1'b0;
         res_overflow = 1'b0;
      end else begin
         res_special  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_y        <= '0;
         out_error    <= 1'b0;
         out_overflow <= 1'b0;
      end else if (load) begin
         out_valid    <= 1'b1;
         out_y        <= res_y;
         out_error    <= res_error;
         out_overflow <= res_overflow;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

`ifdef FP32_ISSUE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_total   <= '0;
         stat_special <= '0;
      end else if (load) begin
         if (stat_total != 16'hFFFF)
            stat_total <= stat_total + 16'd1;
         if (res_special && stat_special != 16'hFFFF)
            stat_special <= stat_special + 16'd1;
      end
   end
`endif

endmodule
